mux_8x1_rr_collector: RTL
=========================

// Module: mux_8x1_rr_collector
// PURPOSE
//  Collects beats from 8 source lanes onto one output channel. Inverse of the 1x8 demux:
//  out_sel carries the 3-bit code of the source lane. Fair round-robin grant,
//  valid/ready on every lane and on the output, one registered output stage.
//  Sits upstream of a single consumer that must know which lane each beat came from.
// PARAMETERS
//  W   8   data width per lane (>=1)
// PORTS
//  clk        in   1    single clock, all logic on rising edge
//  rst_n      in   1    synchronous, active-low reset
//  in_valid   in   8    lane n has a beat
//  in_data    in   8*W  lane n data = in_data[n*W +: W]
//  in_ready   out  8    lane n beat accepted this cycle (one-hot or zero)
//  out_valid  out  1    output beat present
//  out_data   out  W    output beat data
//  out_sel    out  3    source lane of out_data (binary 0..7)
//  out_ready  in   1    consumer accepts the beat
//  out_par    out  1    even parity of out_data (only with MUX8_PARITY_EN)
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_sel=0, out_par=0, ptr=0.
//    in_ready=0 whenever rst_n=0. in_valid is ignored while rst_n=0.
//  - FSM: EMPTY (out_valid=0) and FULL (out_valid=1). load = EMPTY | (FULL & out_ready).
//  - Grant: when load=1 and |in_valid, lane g = the first valid lane at index ptr, ptr+1, ...,
//    ptr+7 (mod 8). in_ready[g]=1 (combinational, same cycle); all other bits 0.
//  - On a grant edge: out_data<=lane g data, out_sel<=g, out_valid<=1, ptr<=g+1 (7 wraps to 0).
//  - load=1 with no valid lane: out_valid<=0 (go EMPTY); out_data/out_sel keep last values.
//  - FULL & !out_ready: hold out_data/out_sel/out_valid stable, in_ready=0, ptr unchanged.
//  - Latency: in_valid&in_ready at edge k -> out_valid=1 after edge k. Throughput 1 beat/cycle
//    when out_ready=1 (drain and refill in the same cycle).
//  - ptr moves only on a grant; a lane that deasserts in_valid before grant loses nothing.
//  - in_data of non-granted lanes never reaches out_data.
//  - Reset mid-transfer: the buffered beat is discarded, grant restarts at lane 0.
// CONFIGURATION
//  MUX8_PARITY_EN defined: port out_par exists; registered with out_data as ^(lane g data),
//    held stable with out_data; reset 0.
//  MUX8_PARITY_EN not defined: no out_par port, no parity logic; all else identical.
// STRUCTURE
//  Package mux8_pkg: LANES=8, SEL_W=3, state enum {EMPTY, FULL}, function that wraps
//    sel+1 to 0.
//  Sub-module rr_pick8: combinational; inputs req[7:0], ptr[2:0]; outputs any, gnt_idx[2:0],
//    gnt_oh[7:0]. Top holds FSM, ptr, output registers and data mux.
// TESTING
//  1 Reset: rst_n=0, in_valid=8'hFF, out_ready=1 -> in_ready=0, out_valid=0, out_sel=0.
//  2 Single lane: in_valid=8'h20, lane5 data=8'hA5 -> in_ready=8'h20; next cycle out_valid=1,
//    out_data=8'hA5, out_sel=5; a later lane5-only request is granted again (ptr=6 wraps).
//  3 Fairness: in_valid=8'hFF held, out_ready=1 -> out_sel 0,1,..,7,0 on consecutive cycles,
//    no idle cycles.
//  4 Backpressure: FULL with out_sel=3, out_ready=0 for 3 cycles -> out_data/out_sel constant,
//    in_ready=0; out_ready=1 -> next lane (4 if valid) loaded in the same cycle.
//  5 Wrap: after a grant of lane 6 (ptr=7), in_valid=8'h81 -> lane 7 first, then lane 0.
//  6 Parity (MUX8_PARITY_EN): lane2 data 8'h07 -> out_par=1; 8'h03 -> out_par=0;
//    build without the macro passes tests 1-5.

Source files
------------

// File: rtl/mux8_pkg.sv
// Shared constants, FSM state type and pointer wrap helper for the 8:1 round-robin collector.
package mux8_pkg;

  localparam int unsigned LANES = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] sel);
    return (sel == SEL_W'(LANES - 1)) ? '0 : sel + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set req bit at index ptr, ptr+1, ... (mod 8).
module rr_pick8
  import mux8_pkg::*;
(
  input  logic [LANES-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] gnt_idx,
  output logic [LANES-1:0] gnt_oh
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    any     = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    idx     = '0;
    for (int i = 0; i < LANES; i++) begin
      // 3-bit add wraps naturally past lane 7
      idx = ptr + SEL_W'(i);
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt_oh[gnt_idx] = any;
  end

endmodule

// File: rtl/mux_8x1_rr_collector.sv
// 8:1 round-robin collector with one registered output stage; out_sel tags the source lane.
// Optional even parity output out_par when MUX8_PARITY_EN is defined.
module mux_8x1_rr_collector
  import mux8_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LANES-1:0]   in_valid,
  input  logic [LANES*W-1:0] in_data,
  output logic [LANES-1:0]   in_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic [SEL_W-1:0]   out_sel,
`ifdef MUX8_PARITY_EN
  output logic               out_par,
`endif
  input  logic               out_ready
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [W-1:0]     data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             load;
  logic             any;
  logic [SEL_W-1:0] gnt_idx;
  logic [LANES-1:0] gnt_oh;
  logic [W-1:0]     gnt_data;

  rr_pick8 u_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .any     (any),
    .gnt_idx (gnt_idx),
    .gnt_oh  (gnt_oh)
  );

  assign load     = (state_q == EMPTY) || out_ready;
  assign gnt_data = in_data[gnt_idx*W +: W];
  // Reset gates the handshake so no lane sees an accept while the stage is being cleared
  assign in_ready = (rst_n && load) ? gnt_oh : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (load) begin
      if (any) begin
        state_d = FULL;
        data_d  = gnt_data;
        sel_d   = gnt_idx;
        ptr_d   = sel_inc(gnt_idx);
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

`ifdef MUX8_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (load && any) begin
      par_q <= ^gnt_data;
    end
  end

  assign out_par = par_q;
`endif

endmodule
